// File: rtl/perm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perm_seq_pkg
// Description : Shared types and constants for the permutation-network
//               sequencer (state encoding, element/seed geometry, LFSR taps).
// Revision    : 1.0 - initial release
// ============================================================================
package perm_seq_pkg;

    localparam int N_ELEM = 16;
    localparam int ELEM_W = 4;
    localparam int SEED_W = 32;

    // Galois right-shift feedback mask applied when the shifted-out bit is 1.
    localparam logic [SEED_W-1:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/perm_lfsr32.sv
`default_nettype none
// ============================================================================
// Module      : perm_lfsr32
// Description : Combinational seed helpers: one Galois LFSR step of the
//               current seed, and zero-sanitization of an externally loaded
//               seed (an all-zero state would lock the LFSR).
// Ports       : seed_cur   in  32  current seed register value
//               seed_raw   in  32  externally supplied seed
//               seed_next  out 32  seed_cur advanced one LFSR step
//               seed_clean out 32  seed_raw, with 0 replaced by 1
// Revision    : 1.0 - initial release
// ============================================================================
module perm_lfsr32
    import perm_seq_pkg::*;
(
    input  logic [SEED_W-1:0] seed_cur,
    input  logic [SEED_W-1:0] seed_raw,
    output logic [SEED_W-1:0] seed_next,
    output logic [SEED_W-1:0] seed_clean
);

    assign seed_next  = (seed_cur >> 1) ^ (seed_cur[0] ? LFSR_TAPS : '0);
    assign seed_clean = (seed_raw == '0) ? SEED_W'(1) : seed_raw;

endmodule
`default_nettype wire

// File: rtl/perm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : perm_seq_ctrl
// Description : Sequencer for the 16-element permutation network. Drives the
//               seed onto rot_pos, waits SETTLE_CYCLES for the combinational
//               network, captures seq_all and streams its 16 nibbles over a
//               valid/ready handshake, then advances the seed by one LFSR step.
// Options     : PERM_CHECK_EN - when defined, flags (sticky perm_err) a
//               captured sequence that is not a permutation of 0..15.
// Ports       : clk, rst (async, active-high)
//               seed_load, seed_in[31:0], start         - control (IDLE only)
//               rot_pos[31:0]                           - network seed drive
//               seq_all[63:0]                           - network result
//               out_valid, out_ready, out_data[3:0],
//               out_index[3:0], out_last                - element stream
//               busy, done, perm_err                    - status
// Revision    : 1.0 - initial release
// ============================================================================
module perm_seq_ctrl
    import perm_seq_pkg::*;
#(
    parameter int                SETTLE_CYCLES = 2,
    parameter logic [SEED_W-1:0] SEED_INIT     = 32'h0000_0001
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     seed_load,
    input  logic [SEED_W-1:0]        seed_in,
    input  logic                     start,
    output logic [SEED_W-1:0]        rot_pos,
    input  logic [N_ELEM*ELEM_W-1:0] seq_all,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ELEM_W-1:0]        out_data,
    output logic [3:0]               out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     perm_err
);

    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] c_last_idx    = 4'(N_ELEM - 1);

    state_e                    r_state;
    logic [3:0]                r_cnt;
    logic [3:0]                r_idx;
    logic [SEED_W-1:0]         r_seed;
    logic [SEED_W-1:0]         r_rot_pos;
    logic [N_ELEM*ELEM_W-1:0]  r_shadow;
    logic                      r_out_valid;
    logic [ELEM_W-1:0]         r_out_data;
    logic                      r_out_last;
    logic                      r_busy;
    logic                      r_done;

    logic [SEED_W-1:0]         w_seed_next;
    logic [SEED_W-1:0]         w_seed_clean;
    logic [3:0]                w_idx_inc;
    logic                      w_capture;
    logic                      w_handshake;

    perm_lfsr32 u_lfsr (
        .seed_cur   (r_seed),
        .seed_raw   (seed_in),
        .seed_next  (w_seed_next),
        .seed_clean (w_seed_clean)
    );

    assign w_idx_inc   = r_idx + 4'd1;
    assign w_capture   = (r_state == ST_SETTLE) && (r_cnt == c_settle_last);
    assign w_handshake = r_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_seed      <= SEED_INIT;
            r_rot_pos   <= '0;
            r_shadow    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (seed_load) begin
                        r_seed <= w_seed_clean;
                    end
                    if (start) begin
                        // A simultaneous load takes precedence over the stored seed.
                        r_rot_pos <= seed_load ? w_seed_clean : r_seed;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_capture) begin
                        // Element 0 is loaded straight from the network so the
                        // output register is valid the cycle after capture.
                        r_shadow    <= seq_all;
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= seq_all[ELEM_W-1:0];
                        r_out_last  <= 1'b0;
                        r_state     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_handshake) begin
                        if (r_idx == c_last_idx) begin
                            r_seed      <= w_seed_next;
                            r_idx       <= '0;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_idx      <= w_idx_inc;
                            r_out_data <= r_shadow[{w_idx_inc, 2'b00} +: ELEM_W];
                            r_out_last <= (w_idx_inc == c_last_idx);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PERM_CHECK_EN
    logic [N_ELEM-1:0] w_seen;
    logic              r_perm_err;

    // Each nibble marks its value; a permutation marks every value exactly once.
    always_comb begin
        w_seen = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            w_seen[seq_all[i*ELEM_W +: ELEM_W]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perm_err <= 1'b0;
        end else if (w_capture && (w_seen != {N_ELEM{1'b1}})) begin
            r_perm_err <= 1'b1;
        end
    end

    assign perm_err = r_perm_err;
`else
    assign perm_err = 1'b0;
`endif

    assign rot_pos   = r_rot_pos;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_idx;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_perm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_perm_seq_ctrl
// Description : Self-checking bench for perm_seq_ctrl. Stimulus pushes the
//               expected element stream into a scoreboard queue; a monitor
//               pops and compares on every handshake. Seed evolution and the
//               permutation flag come from a small reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perm_seq_ctrl;

    localparam logic [31:0] SEED_INIT_TB = 32'h0000_0001;
    localparam logic [31:0] TAPS_TB      = 32'h8020_0003;

    logic        clk;
    logic        rst;
    logic        seed_load;
    logic [31:0] seed_in;
    logic        start;
    logic [31:0] rot_pos;
    logic [63:0] seq_all;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [3:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        perm_err;

    perm_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .start     (start),
        .rot_pos   (rot_pos),
        .seq_all   (seq_all),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .perm_err  (perm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] data;
        logic [3:0] index;
        logic       last;
    } elem_t;

    elem_t       exp_q[$];
    logic [31:0] model_seed;
    bit          exp_perm;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ ((s & 32'd1) != 0 ? TAPS_TB : 32'd0);
    endfunction

    function automatic bit is_perm(input logic [63:0] s);
        bit [15:0] seen = '0;
        for (int i = 0; i < 16; i++) seen[(s >> (4 * i)) & 64'hF] = 1'b1;
        return seen == 16'hFFFF;
    endfunction

    function automatic logic [63:0] rand_perm();
        int          a[16];
        int          j;
        int          t;
        logic [63:0] r = '0;
        for (int i = 0; i < 16; i++) a[i] = i;
        for (int i = 15; i > 0; i--) begin
            j    = $urandom_range(0, i);
            t    = a[i];
            a[i] = a[j];
            a[j] = t;
        end
        for (int i = 0; i < 16; i++) r = r | (64'(a[i]) << (4 * i));
        return r;
    endfunction

    // Monitor: scoreboard pop on each handshake, plus hold-stability while stalled.
    bit         hold_prev = 1'b0;
    logic [3:0] prev_data;
    logic [3:0] prev_index;
    logic       prev_last;
    elem_t      got;

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data",  out_data,  prev_data);
                chk("hold_index", out_index, prev_index);
                chk("hold_last",  out_last,  prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_elem", out_index, 4'hx);
                end else begin
                    got = exp_q.pop_front();
                    chk("elem_data",  out_data,  got.data);
                    chk("elem_index", out_index, got.index);
                    chk("elem_last",  out_last,  got.last);
                end
            end
            hold_prev  = out_valid && !out_ready;
            prev_data  = out_data;
            prev_index = out_index;
            prev_last  = out_last;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rot_pos"},   rot_pos,   32'h0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"},  out_data,  4'h0);
        chk({tag, "_out_index"}, out_index, 4'h0);
        chk({tag, "_out_last"},  out_last,  1'b0);
        chk({tag, "_busy"},      busy,      1'b0);
        chk({tag, "_done"},      done,      1'b0);
        chk({tag, "_perm_err"},  perm_err,  1'b0);
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready 1,0,0,1 then high.
    task automatic do_run(input logic [63:0] seq, input int mode, input bit ld,
                          input logic [31:0] sin, input bit abort7);
        logic [31:0] exp_rot;
        int          s_cyc;
        int          p;
        int          idx1_cnt;
        bit          seen_valid;
        bit          fin;
        bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        elem_t       e;

        @(posedge clk); #1;
        seq_all   = seq;
        start     = 1'b1;
        seed_load = ld;
        seed_in   = sin;
        if (ld) model_seed = (sin == 32'd0) ? 32'd1 : sin;
        exp_rot = model_seed;
        s_cyc   = cyc;
        for (int i = 0; i < 16; i++) begin
            e.data  = 4'((seq >> (4 * i)) & 64'hF);
            e.index = 4'(i);
            e.last  = (i == 15);
            exp_q.push_back(e);
        end
`ifdef PERM_CHECK_EN
        if (!is_perm(seq)) exp_perm = 1'b1;
`endif
        @(posedge clk); #1;
        start     = 1'b0;
        seed_load = 1'b0;
        chk("rot_pos", rot_pos, exp_rot);
        chk("busy_after_start", busy, 1'b1);

        seen_valid = 1'b0;
        fin        = 1'b0;
        p          = 0;
        idx1_cnt   = 0;
        for (int k = 0; k < 400 && !fin; k++) begin
            if (mode == 1)                  out_ready = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && out_valid && p < 4) begin
                out_ready = pat[p];
                p++;
            end else                        out_ready = 1'b1;
            // Control inputs while busy must be ignored.
            if (busy && mode == 1) begin
                start     = 1'($urandom_range(0, 1));
                seed_load = 1'($urandom_range(0, 1));
                seed_in   = $urandom;
            end else begin
                start     = 1'b0;
                seed_load = 1'b0;
            end
            if (abort7 && out_valid && out_index == 4'd7) begin
                start     = 1'b0;
                seed_load = 1'b0;
                #2 rst = 1'b1;
                #1 chk_all_zero("midrst");
                exp_q.delete();
                exp_perm   = 1'b0;
                model_seed = SEED_INIT_TB;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            if (out_valid && !seen_valid) begin
                seen_valid = 1'b1;
                if (mode == 0) chk("first_valid_cycle", cyc - s_cyc, 3);
                chk("perm_err_at_stream", perm_err, exp_perm);
                seq_all = {$urandom, $urandom};
            end
            if (out_valid && out_index == 4'd1) idx1_cnt++;
            if (done) begin
                fin = 1'b1;
                if (mode == 0) chk("done_cycle", cyc - s_cyc, 19);
                if (mode == 2) chk("idx1_hold_cycles", idx1_cnt, 3);
                chk("busy_at_done",  busy,         1'b0);
                chk("valid_at_done", out_valid,    1'b0);
                chk("queue_drained", exp_q.size(), 0);
                chk("perm_err_at_done", perm_err,  exp_perm);
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("done_seen", fin, 1'b1);
        model_seed = lfsr_step(exp_rot);
        start      = 1'b0;
        seed_load  = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        chk("done_pulse_width", done, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        seed_load = 1'b0;
        seed_in   = '0;
        start     = 1'b0;
        seq_all   = '0;
        out_ready = 1'b1;
        exp_perm  = 1'b0;
        model_seed = SEED_INIT_TB;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        do_run(64'hFEDC_BA98_7654_3210, 0, 1'b0, 32'h0, 1'b0);  // rot_pos = 1
        do_run(rand_perm(), 0, 1'b0, 32'h0, 1'b0);              // rot_pos = 8020_0003
        do_run(rand_perm(), 0, 1'b1, 32'h0, 1'b0);              // load 0 + start -> 1
        do_run(64'hFEDC_BA98_7654_3210, 2, 1'b0, 32'h0, 1'b0);  // stall pattern

        // Standalone seed load in IDLE.
        @(posedge clk); #1;
        seed_load = 1'b1;
        seed_in   = $urandom | 32'h0000_0100;
        model_seed = seed_in;
        @(posedge clk); #1;
        seed_load = 1'b0;

        for (int r = 0; r < 6; r++) do_run(rand_perm(), 1, 1'b0, 32'h0, 1'b0);
        do_run(rand_perm(), 1, 1'b1, $urandom, 1'b0);

        do_run(rand_perm(), 0, 1'b0, 32'h0, 1'b1);              // reset at index 7
        do_run(64'hFEDC_BA98_7654_3210, 0, 1'b0, 32'h0, 1'b0);  // rot_pos = SEED_INIT
        do_run(64'h0, 0, 1'b0, 32'h0, 1'b0);                    // non-permutation
        do_run(rand_perm(), 1, 1'b0, 32'h0, 1'b0);              // flag stays sticky

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
